// File: rtl/lut_layer_pkg.sv
// Shared types and constants for the time-multiplexed LUT-neuron layer.
package lut_layer_pkg;

   typedef enum logic [1:0] {StIdle, StGather, StLookup, StDone} state_e;

   localparam logic CFG_SEL_LUT = 1'b0;
   localparam logic CFG_SEL_IDX = 1'b1;

   // Cycle in which out_valid is first high, counting the input handshake cycle as 0.
   function automatic int unsigned eval_latency(int unsigned n_out, int unsigned fanin);
      return n_out * (fanin + 1) + 1;
   endfunction

endpackage

// File: rtl/lut_layer_tables.sv
// Truth-table and connectivity RAMs: synchronous write, asynchronous read.
module lut_layer_tables
   import lut_layer_pkg::*;
#(
   parameter int unsigned N_OUT  = 32,
   parameter int unsigned FANIN  = 8,
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned NRN_W  = 5,
   parameter int unsigned SLOT_W = 3
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [NRN_W-1:0]  wr_nrn,
   input  logic [FANIN-1:0]  wr_addr,
   input  logic [IDX_W-1:0]  wr_data,
   input  logic [NRN_W-1:0]  rd_nrn,
   input  logic [SLOT_W-1:0] rd_slot,
   input  logic [FANIN-1:0]  rd_addr,
   output logic [IDX_W-1:0]  rd_idx,
   output logic              rd_bit
);

   logic [2**FANIN-1:0] lut_mem [N_OUT];
   logic [IDX_W-1:0]    idx_mem [N_OUT][FANIN];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_sel == CFG_SEL_LUT) begin
            lut_mem[wr_nrn][wr_addr] <= wr_data[0];
         end else begin
            idx_mem[wr_nrn][wr_addr[SLOT_W-1:0]] <= wr_data;
         end
      end
   end

   assign rd_idx = idx_mem[rd_nrn][rd_slot];
   assign rd_bit = lut_mem[rd_nrn][rd_addr];

endmodule

// File: rtl/lut_layer_sequencer.sv
// Evaluates one sparse 1-bit LUT-neuron layer by stepping every neuron through
// a single shared gather-and-lookup datapath.
module lut_layer_sequencer
   import lut_layer_pkg::*;
#(
   parameter int unsigned N_IN  = 64,
   parameter int unsigned N_OUT = 32,
   parameter int unsigned FANIN = 8,
   parameter int unsigned IDX_W = $clog2(N_IN),
   parameter int unsigned NRN_W = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic             cfg_sel,
   input  logic [NRN_W-1:0] cfg_nrn,
   input  logic [FANIN-1:0] cfg_addr,
   input  logic [IDX_W-1:0] cfg_data,
   output logic             cfg_err,
   input  logic [N_IN-1:0]  in_vec,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N_OUT-1:0] out_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int unsigned SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;
   localparam int unsigned PAD_W  = 2 ** IDX_W;

   state_e            state;
   logic [N_IN-1:0]   in_reg;
   logic [NRN_W-1:0]  nrn_cnt;
   logic [SLOT_W-1:0] slot_cnt;
   logic [FANIN-1:0]  addr_acc;
   logic [IDX_W-1:0]  gather_idx;
   logic              lut_bit;
   logic [PAD_W-1:0]  in_pad;
   logic              cfg_wr;

   // Tables are only writable while no evaluation is reading them.
   assign cfg_wr   = cfg_we && (state == StIdle);
   // Zero padding makes any index at or beyond N_IN read as 0.
   assign in_pad   = PAD_W'(in_reg);
   assign in_ready = (state == StIdle);
   assign busy     = (state != StIdle);

   lut_layer_tables #(
      .N_OUT  (N_OUT),
      .FANIN  (FANIN),
      .IDX_W  (IDX_W),
      .NRN_W  (NRN_W),
      .SLOT_W (SLOT_W)
   ) u_tables (
      .clk     (clk),
      .wr_en   (cfg_wr),
      .wr_sel  (cfg_sel),
      .wr_nrn  (cfg_nrn),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_nrn  (nrn_cnt),
      .rd_slot (slot_cnt),
      .rd_addr (addr_acc),
      .rd_idx  (gather_idx),
      .rd_bit  (lut_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         out_vec   <= '0;
         out_valid <= 1'b0;
         cfg_err   <= 1'b0;
         nrn_cnt   <= '0;
         slot_cnt  <= '0;
         addr_acc  <= '0;
      end else begin
         cfg_err <= cfg_we && (state != StIdle);
         unique case (state)
            StIdle: begin
               if (in_valid) begin
                  in_reg   <= in_vec;
                  nrn_cnt  <= '0;
                  slot_cnt <= '0;
                  addr_acc <= '0;
                  state    <= StGather;
               end
            end
            StGather: begin
               // Slot k feeds LUT address bit k.
               addr_acc[slot_cnt] <= in_pad[gather_idx];
               if (slot_cnt == SLOT_W'(FANIN - 1)) begin
                  state <= StLookup;
               end else begin
                  slot_cnt <= slot_cnt + SLOT_W'(1);
               end
            end
            StLookup: begin
               out_vec[nrn_cnt] <= lut_bit;
               slot_cnt         <= '0;
               if (nrn_cnt == NRN_W'(N_OUT - 1)) begin
                  out_valid <= 1'b1;
                  state     <= StDone;
               end else begin
                  nrn_cnt <= nrn_cnt + NRN_W'(1);
                  state   <= StGather;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench: a small 8/2/2 layer with hand-derived vectors and corner
// sequences, plus a default 64/32/8 layer against a behavioural reference model.
module tb_lut_layer_sequencer;

   localparam int S_LAT = 2 * (2 + 1) + 1;
   localparam int D_LAT = 32 * (8 + 1) + 1;

   logic clk;
   int   n_cmp = 0;
   int   n_err = 0;

   logic       s_rst, s_cfg_we, s_cfg_sel, s_cfg_err, s_in_valid, s_in_ready;
   logic       s_out_valid, s_out_ready, s_busy;
   logic [0:0] s_cfg_nrn;
   logic [1:0] s_cfg_addr;
   logic [2:0] s_cfg_data;
   logic [7:0] s_in_vec;
   logic [1:0] s_out_vec;

   logic        d_rst, d_cfg_we, d_cfg_sel, d_cfg_err, d_in_valid, d_in_ready;
   logic        d_out_valid, d_out_ready, d_busy;
   logic [4:0]  d_cfg_nrn;
   logic [7:0]  d_cfg_addr;
   logic [5:0]  d_cfg_data;
   logic [63:0] d_in_vec;
   logic [31:0] d_out_vec;

   lut_layer_sequencer #(.N_IN(8), .N_OUT(2), .FANIN(2)) u_small (
      .clk(clk), .rst(s_rst), .cfg_we(s_cfg_we), .cfg_sel(s_cfg_sel), .cfg_nrn(s_cfg_nrn),
      .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data), .cfg_err(s_cfg_err), .in_vec(s_in_vec),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .out_vec(s_out_vec),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .busy(s_busy)
   );

   lut_layer_sequencer u_dflt (
      .clk(clk), .rst(d_rst), .cfg_we(d_cfg_we), .cfg_sel(d_cfg_sel), .cfg_nrn(d_cfg_nrn),
      .cfg_addr(d_cfg_addr), .cfg_data(d_cfg_data), .cfg_err(d_cfg_err), .in_vec(d_in_vec),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .out_vec(d_out_vec),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .busy(d_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct packed {
      logic [7:0] vec;
      logic [1:0] exp;
   } vec_t;

   vec_t       tbl [6];
   int         s_idx [2][2];
   logic [3:0] s_lut [2];
   int         ref_idx [32][8];
   bit         ref_lut [32][256];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic s_cfg(input logic sel, input int nrn, input int addr, input int data);
      @(negedge clk);
      s_cfg_we = 1'b1; s_cfg_sel = sel; s_cfg_nrn = 1'(nrn);
      s_cfg_addr = 2'(addr); s_cfg_data = 3'(data);
      @(negedge clk);
      s_cfg_we = 1'b0;
   endtask

   // Call at a negedge while idle; returns one cycle after the handshake cycle.
   task automatic s_start(input logic [7:0] v);
      s_in_vec = v; s_in_valid = 1'b1;
      chk("s_start_ready", 64'(s_in_ready), 64'd1);
      @(negedge clk);
      s_in_valid = 1'b0;
   endtask

   task automatic s_wait(input int start, output int lat);
      lat = start;
      while (!s_out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic s_drain();
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      chk("s_drain_ready", 64'(s_in_ready), 64'd1);
   endtask

   function automatic logic [31:0] d_ref(input logic [63:0] v);
      logic [31:0] r;
      int a;
      for (int j = 0; j < 32; j++) begin
         a = 0;
         for (int k = 0; k < 8; k++) a += v[ref_idx[j][k]] ? (1 << k) : 0;
         r[j] = ref_lut[j][a];
      end
      return r;
   endfunction

   initial begin
      int          lat;
      int          n;
      logic [63:0] dvec;
      logic [31:0] dexp;

      s_idx = '{'{3, 5}, '{0, 7}};
      s_lut = '{4'b1000, 4'b0110};
      tbl[0] = '{vec: 8'b0010_1001, exp: 2'b11};
      tbl[1] = '{vec: 8'b1000_0000, exp: 2'b10};
      tbl[2] = '{vec: 8'h00,        exp: 2'b00};
      tbl[3] = '{vec: 8'h28,        exp: 2'b01};
      tbl[4] = '{vec: 8'h81,        exp: 2'b00};
      tbl[5] = '{vec: 8'h08,        exp: 2'b00};

      s_rst = 1'b1; s_cfg_we = 1'b0; s_cfg_sel = 1'b0; s_cfg_nrn = '0; s_cfg_addr = '0;
      s_cfg_data = '0; s_in_vec = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      d_rst = 1'b1; d_cfg_we = 1'b0; d_cfg_sel = 1'b0; d_cfg_nrn = '0; d_cfg_addr = '0;
      d_cfg_data = '0; d_in_vec = '0; d_in_valid = 1'b0; d_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("s_rst_out_vec", 64'(s_out_vec), 64'd0);
      chk("s_rst_out_valid", 64'(s_out_valid), 64'd0);
      chk("s_rst_cfg_err", 64'(s_cfg_err), 64'd0);
      chk("s_rst_in_ready", 64'(s_in_ready), 64'd1);
      chk("s_rst_busy", 64'(s_busy), 64'd0);
      chk("d_rst_out_vec", 64'(d_out_vec), 64'd0);
      chk("d_rst_out_valid", 64'(d_out_valid), 64'd0);
      s_rst = 1'b0; d_rst = 1'b0;

      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < 2; k++) s_cfg(1'b1, j, k, s_idx[j][k]);
         for (int e = 0; e < 4; e++) s_cfg(1'b0, j, e, int'(s_lut[j][e]));
      end
      chk("s_cfg_idle_err", 64'(s_cfg_err), 64'd0);

      for (int i = 0; i < 6; i++) begin
         s_start(tbl[i].vec);
         s_wait(1, lat);
         chk("s_tbl_out_vec", 64'(s_out_vec), 64'(tbl[i].exp));
         chk("s_tbl_latency", 64'(lat), 64'(S_LAT));
         s_drain();
      end

      // Backpressure: result and status hold, a second input is refused.
      s_start(8'b0010_1001);
      s_wait(1, lat);
      for (int c = 0; c < 20; c++) begin
         s_in_valid = 1'b1; s_in_vec = 8'h00;
         @(negedge clk);
         chk("s_bp_hold", 64'({s_out_valid, s_busy, s_in_ready, s_out_vec}), 64'b11011);
      end
      s_in_valid = 1'b0; s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      chk("s_bp_release", 64'({s_in_ready, s_out_valid, s_busy}), 64'b100);
      @(negedge clk);
      chk("s_bp_no_second", 64'(s_busy), 64'd0);

      // Config write during GATHER is rejected with a one-cycle error pulse.
      s_start(8'b0010_1001);
      s_cfg_we = 1'b1; s_cfg_sel = 1'b0; s_cfg_nrn = 1'b0; s_cfg_addr = 2'd3; s_cfg_data = 3'd0;
      @(negedge clk);
      s_cfg_we = 1'b0;
      chk("s_cfg_err_pulse", 64'(s_cfg_err), 64'd1);
      @(negedge clk);
      chk("s_cfg_err_clear", 64'(s_cfg_err), 64'd0);
      s_wait(3, lat);
      chk("s_cfg_rejected_vec", 64'(s_out_vec), 64'b11);
      s_drain();
      s_cfg(1'b0, 0, 3, 0);
      chk("s_cfg_accept_err", 64'(s_cfg_err), 64'd0);
      s_start(8'b0010_1001);
      s_wait(1, lat);
      chk("s_cfg_applied_vec", 64'(s_out_vec), 64'b10);
      s_drain();
      s_cfg(1'b0, 0, 3, 1);

      // Reset during LOOKUP of neuron 0 aborts; tables survive.
      s_start(8'b0010_1001);
      @(negedge clk);
      @(negedge clk);
      s_rst = 1'b1;
      @(negedge clk);
      s_rst = 1'b0;
      chk("s_abort_state", 64'({s_busy, s_out_valid, s_in_ready}), 64'b001);
      chk("s_abort_out_vec", 64'(s_out_vec), 64'd0);
      s_start(8'b0010_1001);
      s_wait(1, lat);
      chk("s_rerun_vec", 64'(s_out_vec), 64'b11);
      chk("s_rerun_latency", 64'(lat), 64'(S_LAT));
      s_drain();

      // Default geometry: random tables, random vectors, random backpressure.
      for (int j = 0; j < 32; j++) begin
         for (int k = 0; k < 8; k++) begin
            ref_idx[j][k] = int'($urandom_range(0, 63));
            @(negedge clk);
            d_cfg_we = 1'b1; d_cfg_sel = 1'b1; d_cfg_nrn = 5'(j);
            d_cfg_addr = 8'(k); d_cfg_data = 6'(ref_idx[j][k]);
         end
         for (int e = 0; e < 256; e++) begin
            ref_lut[j][e] = 1'($urandom);
            @(negedge clk);
            d_cfg_we = 1'b1; d_cfg_sel = 1'b0; d_cfg_nrn = 5'(j);
            d_cfg_addr = 8'(e); d_cfg_data = {5'b0, ref_lut[j][e]};
         end
      end
      @(negedge clk);
      d_cfg_we = 1'b0;
      @(negedge clk);
      chk("d_cfg_err", 64'(d_cfg_err), 64'd0);

      for (int t = 0; t < 200; t++) begin
         dvec = {$urandom, $urandom};
         dexp = d_ref(dvec);
         d_in_vec = dvec; d_in_valid = 1'b1;
         n = 0;
         while (!d_in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         @(negedge clk);
         d_in_valid = 1'b0;
         lat = 1;
         while (!d_out_valid && lat < 400) begin
            d_out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
         end
         chk("d_latency", 64'(lat), 64'(D_LAT));
         chk("d_out_vec", 64'(d_out_vec), 64'(dexp));
         n = 0;
         do begin
            d_out_ready = 1'($urandom);
            @(negedge clk);
            n++;
         end while (!d_out_ready && n < 100);
         d_out_ready = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lut_layer_sequencer.md
Name: lut_layer_sequencer

Overview:
- Time-multiplexed evaluator for one sparse LUT-neuron layer with 1-bit activations.
- Holds a runtime-configurable truth table (2^FANIN bits per neuron) and a connectivity table (FANIN input indices per neuron) in distributed RAM.
- Sequences all N_OUT neurons through a single shared gather-and-lookup datapath, replacing N_OUT fixed combinational LUT instances.
- Sits between two layer stages; both the input and output sides use valid/ready handshakes.

Parameters:
- N_IN, 64, input activation vector width.
- N_OUT, 32, neurons in the layer (output vector width).
- FANIN, 8, inputs per neuron; LUT depth per neuron is 2^FANIN.
- IDX_W, $clog2(N_IN), width of one connectivity index.
- NRN_W, $clog2(N_OUT), neuron index width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  1  0 = LUT table, 1 = connectivity table.
- cfg_nrn  in  NRN_W  target neuron.
- cfg_addr  in  FANIN  LUT entry address (cfg_sel=0), or fan-in slot in the low $clog2(FANIN) bits (cfg_sel=1).
- cfg_data  in  IDX_W  LUT bit in bit 0 (cfg_sel=0), or input index (cfg_sel=1).
- cfg_err  out  1  one-cycle pulse: a write was rejected.
- in_vec  in  N_IN  input activations.
- in_valid  in  1  input handshake valid.
- in_ready  out  1  high only in IDLE.
- out_vec  out  N_OUT  layer result; bit j = neuron j.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, out_vec=0, out_valid=0, cfg_err=0, nrn_cnt=0, slot_cnt=0, addr_acc=0.
- Reset does not clear the table RAMs; their contents persist across rst.
- rst asserted mid-evaluation aborts the evaluation; the next cycle is IDLE with out_valid=0.
- FSM states: IDLE, GATHER, LOOKUP, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture in_vec into in_reg, clear nrn_cnt, slot_cnt and addr_acc, then go to GATHER.
  - When cfg_we is high in IDLE, perform the write on the same edge.
- GATHER (one cycle per fan-in slot):
  - Read the connectivity table combinationally at (nrn_cnt, slot_cnt).
  - addr_acc[slot_cnt] <= in_reg[index]. Fan-in slot k drives LUT address bit k, so slot 0 is the LSB.
  - An index >= N_IN selects 0.
  - After slot FANIN-1, go to LOOKUP.
- LOOKUP (one cycle):
  - out_vec[nrn_cnt] <= lut[nrn_cnt][addr_acc]; clear slot_cnt.
  - If nrn_cnt == N_OUT-1, go to DONE; otherwise increment nrn_cnt and return to GATHER.
- DONE:
  - out_valid=1 and out_vec holds stable.
  - On out_valid && out_ready, clear out_valid and go to IDLE.
  - in_ready stays 0 until that IDLE cycle, so there is no back-to-back overlap.
- Latency:
  - Handshake edge at cycle 0; out_valid rises at cycle N_OUT*(FANIN+1)+1.
  - Throughput is one vector per N_OUT*(FANIN+1)+2 cycles at minimum.
- cfg_we outside IDLE: no write, cfg_err=1 for one cycle. Tables are never modified mid-evaluation.
- cfg_we together with in_valid in IDLE: the config write takes effect and the evaluation starts on the same edge. No table entry is read before the next edge, so the new value is used.
- out_vec bits of neurons not yet evaluated keep their previous values during evaluation. Only DONE guarantees a coherent vector.

Decomposition:
- Shared package lut_layer_pkg:
  - state enum (IDLE/GATHER/LOOKUP/DONE);
  - CFG_SEL_LUT=0, CFG_SEL_IDX=1;
  - a localparam function computing latency for benches.
- One natural sub-module: lut_layer_tables.
  - Two distributed-RAM arrays with synchronous write and asynchronous read.
  - Ports: write port plus read addresses (nrn, slot) and (nrn, addr).
- The FSM, counters, in_reg and out_vec stay in lut_layer_sequencer.

Test Plan:
- N_IN=8, N_OUT=2, FANIN=2:
  - config: neuron 0 idx={3,5}, LUT=AND (entry 3 = 1 only); neuron 1 idx={0,7}, LUT=XOR (entries 1 and 2 = 1).
  - in_vec=8'b0010_1001 -> out_vec=2'b11, out_valid rising exactly 7 cycles after the handshake edge.
- Same config, in_vec=8'b1000_0000 -> out_vec=2'b10; in_vec=8'h00 -> out_vec=2'b00.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid, out_vec and busy stay stable, in_ready=0, and a second in_valid is not accepted; after out_ready=1, IDLE and in_ready=1 on the next cycle.
- cfg_we during GATHER -> cfg_err pulses exactly 1 cycle and the result matches the pre-write table; the same write in IDLE is then accepted and changes the next result.
- rst asserted during LOOKUP of neuron 0 -> next cycle IDLE, out_valid=0, out_vec=0, in_ready=1; a re-run with the same vector gives the correct result, since the tables are retained.
- Defaults (64/32/8): program a random table; drive 200 random vectors with random out_ready -> compare against a reference model; latency 289 cycles each.
